c3lib_ckg_ctrl: RTL



---
 rtl/c3lib_ckg_ctrl_pkg.sv | 19 +
 rtl/c3lib_ckg_lvt_8x.sv | 18 +
 rtl/c3lib_ckg_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/c3lib_ckg_ctrl_pkg.sv
// Shared types and limits for the clock-gate controller.
// State encoding plus counter widths derived from parameter ranges.
package c3lib_ckg_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } ckg_state_e;

  localparam int ON_DLY_MAX   = 15;
  localparam int IDLE_DLY_MAX = 255;

  localparam int ON_CNT_W   = $clog2(ON_DLY_MAX + 1);
  localparam int IDLE_CNT_W = $clog2(IDLE_DLY_MAX + 1);
  localparam int STAT_W     = 16;

endpackage

// File: rtl/c3lib_ckg_lvt_8x.sv
// Latch-based positive-edge clock gater: enable captured while clk is low.
// Ports: clk, clk_en, tst_en (bypass) -> gated_clk.
module c3lib_ckg_lvt_8x (
  input  logic clk,
  input  logic clk_en,
  input  logic tst_en,
  output logic gated_clk
);

  logic en_l;

  always_latch begin
    if (!clk) en_l <= clk_en | tst_en;
  end

  assign gated_clk = clk & en_l;

endmodule

// File: rtl/c3lib_ckg_ctrl.sv
// Clock-gate controller: aggregates requests, wakes/acks/idles the gater.
// Ports: clk, rst_n, req, ack, force_on, tst_en, gated_clk, clk_on, busy;
// optional wake_cnt/stats_clr when C3LIB_CKG_CTRL_STATS_EN is defined.
module c3lib_ckg_ctrl
  import c3lib_ckg_ctrl_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ON_DLY   = 2,
  parameter int IDLE_DLY = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  input  logic               force_on,
  input  logic               tst_en,
  output logic               gated_clk,
  output logic               clk_on,
`ifdef C3LIB_CKG_CTRL_STATS_EN
  output logic [STAT_W-1:0]  wake_cnt,
  input  logic               stats_clr,
`endif
  output logic               busy
);

  localparam logic [ON_CNT_W-1:0] ON_LD =
    ON_CNT_W'(ON_DLY - 1);
  localparam logic [IDLE_CNT_W-1:0] IDLE_LD =
    IDLE_CNT_W'(IDLE_DLY - 1);

  ckg_state_e state_q, state_d;
  logic [ON_CNT_W-1:0]   won_q, won_d;
  logic [IDLE_CNT_W-1:0] idl_q, idl_d;
  logic                  clk_on_q, clk_on_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  any_req;

  assign any_req = (|req) | force_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OFF;
      won_q    <= '0;
      idl_q    <= '0;
      clk_on_q <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      won_q    <= won_d;
      idl_q    <= idl_d;
      clk_on_q <= clk_on_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    won_d    = won_q;
    idl_d    = idl_q;
    clk_on_d = 1'b1;
    unique case (state_q)
      OFF: begin
        clk_on_d = 1'b0;
        if (any_req) begin
          state_d  = WAKE;
          clk_on_d = 1'b1;
          won_d    = ON_LD;
        end
      end
      WAKE: begin
        if (won_q == '0) state_d = ON;
        else             won_d   = won_q - 1'b1;
      end
      ON: begin
        if (!any_req) begin
          state_d = IDLE;
          idl_d   = IDLE_LD;
        end
      end
      IDLE: begin
        if (any_req) begin
          state_d = ON;
        end else if (idl_q == '0) begin
          state_d  = OFF;
          clk_on_d = 1'b0;
        end else begin
          idl_d = idl_q - 1'b1;
        end
      end
      default: begin
        state_d  = OFF;
        clk_on_d = 1'b0;
      end
    endcase
    // ack is registered alongside the state so it is high only in ON
    ack_d = (state_d == ON) ? req : '0;
  end

  assign ack    = ack_q;
  assign clk_on = clk_on_q;
  assign busy   = (state_q != OFF);

`ifdef C3LIB_CKG_CTRL_STATS_EN
  logic [STAT_W-1:0] wake_q;
  logic              wake_ev;

  assign wake_ev = (state_q == OFF) && (state_d == WAKE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wake_q <= '0;
    else if (stats_clr)             wake_q <= '0;
    else if (wake_ev && ~&wake_q)   wake_q <= wake_q + 1'b1;
  end

  assign wake_cnt = wake_q;
`endif

  c3lib_ckg_lvt_8x gater (
    .clk       (clk),
    .clk_en    (clk_on_q),
    .tst_en    (tst_en),
    .gated_clk (gated_clk)
  );

endmodule
